// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port among N requesters
module fifo_wr_arbiter #(
    parameter int DW        = 8,
    parameter int IDW       = 2,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [(1<<IDW)-1:0]        req_valid,
    input  logic [(1<<IDW)*DW-1:0]     req_data,
    output logic [(1<<IDW)-1:0]        req_ready,
    input  logic                       fifo_full,
    output logic                       fifo_we,
    output logic [DW-1:0]              fifo_wdata,
    output logic [IDW-1:0]             grant_id,
    output logic                       busy
);
    localparam int N = 1 << IDW;
    localparam int BW = MAX_BURST > 1 ? $clog2(MAX_BURST) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          r_state;
    logic [IDW-1:0]  r_grant;
    logic [IDW-1:0]  r_last;
    logic [BW-1:0]   r_beat;
    logic [IDW-1:0]  w_win;
    logic [IDW-1:0]  w_idx;
    logic            w_valid;
    logic            w_xfer;
    logic [DW-1:0]   w_lane [N];

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_lane
            assign w_lane[g] = req_data[g*DW +: DW];
        end
    endgenerate

    // round-robin pick: scan offsets from far to near so the nearest valid one after last wins
    always_comb begin
        w_win = r_last;
        w_idx = r_last;
        for (int k = N; k >= 1; k--) begin
            w_idx = r_last + IDW'(k);
            if (req_valid[w_idx]) w_win = w_idx;
        end
    end

    assign w_valid    = req_valid[r_grant];
    assign w_xfer     = !reset && r_state == GRANT && w_valid && !fifo_full;
    assign req_ready  = {N{w_xfer}} & (N'(1) << r_grant);
    assign fifo_we    = w_xfer;
    assign fifo_wdata = r_state == GRANT ? w_lane[r_grant] : '0;
    assign grant_id   = r_grant;
    assign busy       = r_state == GRANT;

    // grant on any valid in IDLE; release on burst limit or when the owner drops valid
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_last  <= IDW'(N - 1);
            r_beat  <= '0;
        end else if (r_state == IDLE) begin
            if (|req_valid) begin
                r_state <= GRANT;
                r_grant <= w_win;
                r_last  <= w_win;
            end
        end else if (!w_valid || (w_xfer && r_beat == LAST_BEAT)) begin
            r_state <= IDLE;
            r_beat  <= '0;
        end else if (w_xfer) begin
            r_beat <= r_beat + BW'(1);
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed scenarios checked against a per-cycle behavioural model
module tb_fifo_wr_arbiter;
    localparam int N = 4;
    localparam int MB = 4;

    logic        clk = 0;
    logic        reset = 1;
    logic        fifo_full = 0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic        fifo_we;
    logic [7:0]  fifo_wdata;
    logic [1:0]  grant_id;
    logic        busy;

    fifo_wr_arbiter #(.DW(8), .IDW(2), .MAX_BURST(MB)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .fifo_full(fifo_full), .fifo_we(fifo_we),
        .fifo_wdata(fifo_wdata), .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int base = 0;
    bit en = 0;
    int left [N];
    logic [7:0] dat [N];
    logic [3:0] hs;
    int wq_c[$], wq_d[$], wq_g[$], gq_c[$], gq_g[$];
    int m_owner = -1, m_gid = 0, m_last = N - 1, m_beats = 0;
    bit mx;
    int sel;
    logic pb = 0;
    int e1 [6] = '{1, 2, 3, 4, 6, 7};
    int e3 [6] = '{1, 2, 6, 7, 9, 10};

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // model: owner is whoever holds the grant (-1 when idle), beats counts writes in this grant
    always @(negedge clk) begin
        sel = m_owner < 0 ? 0 : m_owner;
        mx = !reset && m_owner >= 0 && req_valid[sel] && !fifo_full;
        if (en) begin
            chk("busy", busy, m_owner >= 0);
            chk("grant_id", grant_id, m_gid);
            chk("fifo_we", fifo_we, mx);
            chk("req_ready", req_ready, mx ? (1 << sel) : 0);
            chk("fifo_wdata", fifo_wdata, m_owner >= 0 ? req_data[sel*8 +: 8] : 0);
            chk("ready_onehot", $countones(req_ready) <= 1, 1);
            if (fifo_we) begin
                wq_c.push_back(cyc - base);
                wq_d.push_back(fifo_wdata);
                wq_g.push_back(grant_id);
            end
            if (busy && !pb) begin
                gq_c.push_back(cyc - base);
                gq_g.push_back(grant_id);
            end
            pb = busy;
        end
        if (reset) begin
            m_owner = -1; m_gid = 0; m_last = N - 1; m_beats = 0; en = 1;
        end else if (m_owner < 0) begin
            for (int k = 1; k <= N; k++)
                if (m_owner < 0 && req_valid[(m_last + k) % N]) m_owner = (m_last + k) % N;
            if (m_owner >= 0) begin
                m_gid = m_owner;
                m_last = m_owner;
            end
        end else if (!req_valid[m_owner]) begin
            m_owner = -1; m_beats = 0;
        end else if (mx) begin
            m_beats++;
            if (m_beats == MB) begin
                m_owner = -1; m_beats = 0;
            end
        end
    end

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = left[i] > 0;
            req_data[i*8 +: 8] = dat[i];
        end
    endtask

    task automatic tick();
        @(negedge clk);
        hs = req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (hs[i]) begin
                dat[i]++;
                left[i]--;
            end
        drive();
    endtask

    task automatic start();
        wq_c.delete(); wq_d.delete(); wq_g.delete(); gq_c.delete(); gq_g.delete();
        base = cyc;
    endtask

    task automatic rst_pulse();
        for (int i = 0; i < N; i++) left[i] = 0;
        fifo_full = 0;
        drive();
        reset = 1;
        tick();
        reset = 0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            left[i] = 0;
            dat[i] = '0;
        end
        tick();
        tick();
        reset = 0;
        #1;
        chk("rst busy", busy, 0);
        chk("rst grant_id", grant_id, 0);
        chk("rst wdata", fifo_wdata, 0);
        chk("rst we", fifo_we, 0);
        chk("rst ready", req_ready, 0);

        // single requester, 6 beats over two grants
        start();
        left[1] = 6; dat[1] = 8'h10; drive();
        repeat (10) tick();
        chk("s1 nwrites", wq_d.size(), 6);
        for (int i = 0; i < 6 && i < wq_d.size(); i++) begin
            chk($sformatf("s1 data%0d", i), wq_d[i], 'h10 + i);
            chk($sformatf("s1 cyc%0d", i), wq_c[i], e1[i]);
            chk($sformatf("s1 gid%0d", i), wq_g[i], 1);
        end

        // all four requesters streaming
        rst_pulse(); start();
        for (int i = 0; i < N; i++) begin
            left[i] = 1000; dat[i] = 8'(i * 'h40);
        end
        drive();
        repeat (23) tick();
        chk("s2 ngrants", gq_g.size(), 5);
        chk("s2 nwrites", wq_d.size(), 18);
        for (int i = 0; i < 5 && i < gq_g.size(); i++) begin
            chk($sformatf("s2 gid%0d", i), gq_g[i], i % 4);
            chk($sformatf("s2 gcyc%0d", i), gq_c[i], 1 + 5 * i);
        end

        // backpressure after beat 2
        rst_pulse(); start();
        left[0] = 6; dat[0] = 8'h20; drive();
        repeat (3) tick();
        fifo_full = 1;
        repeat (3) tick();
        fifo_full = 0;
        repeat (8) tick();
        chk("s3 nwrites", wq_d.size(), 6);
        for (int i = 0; i < 6 && i < wq_d.size(); i++) begin
            chk($sformatf("s3 data%0d", i), wq_d[i], 'h20 + i);
            chk($sformatf("s3 cyc%0d", i), wq_c[i], e3[i]);
        end
        chk("s3 ngrants", gq_c.size(), 2);
        if (gq_c.size() == 2) chk("s3 regrant cyc", gq_c[1], 9);

        // early release with requester 2 waiting
        rst_pulse(); start();
        left[0] = 2; dat[0] = 8'h30; left[2] = 10; dat[2] = 8'h60; drive();
        repeat (8) tick();
        chk("s4 ngrants", gq_g.size() >= 2, 1);
        if (gq_g.size() >= 2) begin
            chk("s4 g0", gq_g[0], 0);
            chk("s4 g1", gq_g[1], 2);
            chk("s4 g1 cyc", gq_c[1], 5);
        end
        chk("s4 nwrites", wq_d.size() >= 3, 1);
        if (wq_d.size() >= 3) begin
            chk("s4 w2 cyc", wq_c[2], 5);
            chk("s4 w2 data", wq_d[2], 'h60);
        end

        // reset during beat 3 of requester 3
        rst_pulse(); start();
        left[3] = 10; dat[3] = 8'h70; drive();
        repeat (3) tick();
        reset = 1;
        #1;
        chk("s5 rst we", fifo_we, 0);
        chk("s5 rst ready", req_ready, 0);
        tick();
        reset = 0;
        for (int i = 0; i < N; i++) left[i] = 100;
        drive();
        #1;
        chk("s5 busy", busy, 0);
        chk("s5 grant_id", grant_id, 0);
        chk("s5 wdata", fifo_wdata, 0);
        repeat (3) tick();
        chk("s5 nwrites", wq_d.size() >= 3, 1);
        if (wq_d.size() >= 3) begin
            chk("s5 w1 cyc", wq_c[1], 2);
            chk("s5 w2 cyc", wq_c[2], 5);
            chk("s5 w2 gid", wq_g[2], 0);
        end
        chk("s5 ngrants", gq_g.size(), 2);
        if (gq_g.size() == 2) chk("s5 g1", gq_g[1], 0);

        // full while idle: grant happens, writes wait
        rst_pulse(); start();
        fifo_full = 1;
        left[2] = 3; dat[2] = 8'h50; drive();
        repeat (4) tick();
        chk("s6 busy", busy, 1);
        chk("s6 gid", grant_id, 2);
        chk("s6 we", fifo_we, 0);
        fifo_full = 0;
        repeat (5) tick();
        chk("s6 nwrites", wq_d.size(), 3);
        for (int i = 0; i < 3 && i < wq_d.size(); i++) begin
            chk($sformatf("s6 cyc%0d", i), wq_c[i], 4 + i);
            chk($sformatf("s6 data%0d", i), wq_d[i], 'h50 + i);
        end
        rst_pulse();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
